// File: rtl/dev_io_pkg.sv
// Shared definitions for the board-side device I/O controller.
//   io_state_t    : input-handshake FSM states
//   ENTER_REQ     : enter_out bit carrying the processor's input request level
//   ENTER_NEW_OUT : enter_out bit carrying the new-output-word pulse
//   ENTER_READY   : enter_in bit carrying the one-cycle input-ready pulse
package dev_io_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      WAIT_PRESS   = 2'd1,
      ACK          = 2'd2,
      WAIT_RELEASE = 2'd3
   } io_state_t;

   localparam int ENTER_REQ     = 0;
   localparam int ENTER_NEW_OUT = 1;
   localparam int ENTER_READY   = 0;

endpackage

// File: rtl/dev_io_ctrl_debouncer.sv
// Enter-button conditioning: 2-flop synchronizer, stability counter,
// debounced level and a one-cycle rise pulse.
// Ports:
//   clk, reset : system clock, synchronous active-high reset
//   btn_raw    : raw asynchronous button input
//   db_level   : debounced button level
//   db_rise    : one-cycle pulse on a debounced 0->1 transition
// A raw level present at edge E shows up as db_rise sampled at edge
// E+2+DEBOUNCE_CYCLES.
module debouncer
   import dev_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic db_level,
   output logic db_rise
);

   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   logic          sync_1;
   logic          sync_2;
   logic [CW-1:0] cnt;
   logic          differ;
   logic          flip;

   assign differ = (sync_2 != db_level);
   // The sample that would bring the count to DEBOUNCE_CYCLES flips the level.
   assign flip   = differ && (cnt == CNT_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         cnt      <= '0;
         db_level <= 1'b0;
         db_rise  <= 1'b0;
      end else begin
         sync_1  <= btn_raw;
         sync_2  <= sync_1;
         db_rise <= flip && !db_level;
         if (!differ) begin
            cnt <= '0;
         end else if (flip) begin
            cnt      <= '0;
            db_level <= ~db_level;
         end else begin
            cnt <= cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dev_io_ctrl.sv
// Board-side I/O controller for the processor device port.
// Debounces the enter button, serves input requests with a one-cycle
// ready pulse and latches processor output words for the display.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   sw          : raw switches, captured into dev_in on a button press
//   btn_enter   : raw bouncing enter button
//   dev_out     : processor output word (only [31:0] is used)
//   enter_out   : [0] input request level, [1] new-output pulse
//   dev_in      : captured switch word, zero-extended
//   enter_in    : [0] input-ready pulse, other bits 0
//   display     : last output word (or instruction count, see below)
//   waiting     : LED, high while an input request waits for a press
//   out_count   : wrapping count of output strobes
// Build option INST_COUNT_EN: adds done_inst / inst_count; display shows
// inst_count while sw[SW_WIDTH-1] is set and the FSM is idle.
//
// state        | meaning
// IDLE         | no request pending
// WAIT_PRESS   | request pending, waiting for a debounced press
// ACK          | switches captured, ready pulse out this cycle
// WAIT_RELEASE | press consumed, waiting for release and request drop
module dev_io_ctrl
   import dev_io_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int SW_WIDTH        = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [SW_WIDTH-1:0] sw,
   input  logic                btn_enter,
   input  logic [127:0]        dev_out,
   input  logic [3:0]          enter_out,
   output logic [127:0]        dev_in,
   output logic [3:0]          enter_in,
   output logic [31:0]         display,
   output logic                waiting,
   output logic [7:0]          out_count
`ifdef INST_COUNT_EN
   ,
   input  logic                done_inst,
   output logic [31:0]         inst_count
`endif
);

   io_state_t   state;
   io_state_t   state_nxt;
   logic        capture;
   logic        db_level;
   logic        db_rise;
   logic        req;
   logic [31:0] out_word;
   logic        unused_bits;

   assign req         = enter_out[ENTER_REQ];
   assign unused_bits = ^{dev_out[127:32], enter_out[3:2]};

   debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_enter),
      .db_level (db_level),
      .db_rise  (db_rise)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      capture   = 1'b0;
      unique case (state)
         IDLE: begin
            if (req) state_nxt = WAIT_PRESS;
         end
         WAIT_PRESS: begin
            // Dropping the request wins over a coincident press.
            if (!req) begin
               state_nxt = IDLE;
            end else if (db_rise) begin
               capture   = 1'b1;
               state_nxt = ACK;
            end
         end
         ACK: begin
            state_nxt = WAIT_RELEASE;
         end
         WAIT_RELEASE: begin
            if (!db_level && !req) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      enter_in              = '0;
      enter_in[ENTER_READY] = (state == ACK);
   end

   assign waiting = (state == WAIT_PRESS);

   always_ff @(posedge clk) begin
      if (reset) begin
         dev_in <= '0;
      end else if (capture) begin
         dev_in <= 128'(sw);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         out_word  <= '0;
         out_count <= '0;
      end else if (enter_out[ENTER_NEW_OUT]) begin
         out_word  <= dev_out[31:0];
         out_count <= out_count + 8'd1;
      end
   end

`ifdef INST_COUNT_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         inst_count <= '0;
      end else if (done_inst) begin
         inst_count <= inst_count + 32'd1;
      end
   end

   assign display = (sw[SW_WIDTH-1] && (state == IDLE)) ? inst_count : out_word;
`else
   assign display = out_word;
`endif

endmodule
